// File: rtl/ghost_pkg.sv
// Shared ghost-movement types: one-hot direction codes, FSM states, map size.
// Also holds the reverse-direction and rotating-priority pick helpers.
package ghost_pkg;

    localparam logic [3:0] DIR_DOWN  = 4'b1000;
    localparam logic [3:0] DIR_UP    = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0001;

    localparam int MAP_W = 40;
    localparam int MAP_H = 28;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_DECIDE = 2'd1,
        ST_MOVE   = 2'd2
    } state_t;

    // Swaps down<->up and right<->left; zero maps to zero.
    function automatic logic [3:0] rev_dir(input logic [3:0] d);
        return {d[2], d[3], d[0], d[1]};
    endfunction

    // First set bit of cand scanning start, start+1, ... modulo 4.
    function automatic logic [3:0] pick_dir(input logic [3:0] cand, input logic [1:0] start);
        logic [3:0] res;
        logic [1:0] idx;
        res = '0;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (cand[idx]) res = 4'b0001 << idx;
        end
        return res;
    endfunction

endpackage

// File: rtl/ghost_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1); free-running, one step per clock.
// Holds SEED while in reset; exposes the two low state bits as a random index.
module ghost_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       i_clk,
    input  logic       i_rst,
    output logic [1:0] o_rnd
);

    logic [7:0] r_lfsr;
    logic       w_fb;

    assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge i_clk) begin
        if (i_rst) r_lfsr <= SEED;
        else       r_lfsr <= {r_lfsr[6:0], w_fb};
    end

    assign o_rnd = r_lfsr[1:0];

endmodule

// File: rtl/ghost_move.sv
// Ghost mover: tick -> DECIDE -> MOVE, position/dir update 2 clocks after the tick; ticks while busy are dropped.
// Optional GHOST_CHASE_EN adds target ports and steers the choice toward the target.
module ghost_move
    import ghost_pkg::*;
#(
    parameter int unsigned START_X   = 20,
    parameter int unsigned START_Y   = 13,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_step_tick,
    input  logic [3:0] i_valid,
`ifdef GHOST_CHASE_EN
    input  logic [9:0] i_target_x,
    input  logic [9:0] i_target_y,
`endif
    output logic [9:0] o_block_x_reg,
    output logic [9:0] o_block_y_reg,
    output logic [3:0] o_dir,
    output logic       o_moving,
    output logic       o_stuck
);

    state_t     r_state;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic [3:0] r_dir;
    logic [3:0] r_next_dir;
    logic       r_moving;
    logic       r_stuck;

    logic [1:0] w_rnd;
    logic [3:0] w_cand_fwd;
    logic [3:0] w_cand;
    logic [3:0] w_pick;
    logic [3:0] w_choice;

    ghost_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .o_rnd (w_rnd)
    );

    // Prefer not to reverse; at a dead end the reversal is the only way out.
    assign w_cand_fwd = i_valid & ~rev_dir(r_dir);
    assign w_cand     = (w_cand_fwd == 4'b0000) ? i_valid : w_cand_fwd;
    assign w_pick     = pick_dir(w_cand, w_rnd);

`ifdef GHOST_CHASE_EN
    logic [9:0] w_dx_abs;
    logic [9:0] w_dy_abs;
    logic [3:0] w_toward_x;
    logic [3:0] w_toward_y;
    logic [3:0] w_pref;
    logic [3:0] w_minor;
    logic       w_x_major;

    assign w_dx_abs   = (i_target_x >= r_x) ? (i_target_x - r_x) : (r_x - i_target_x);
    assign w_dy_abs   = (i_target_y >= r_y) ? (i_target_y - r_y) : (r_y - i_target_y);
    assign w_toward_x = (i_target_x < r_x) ? DIR_LEFT : ((i_target_x > r_x) ? DIR_RIGHT : 4'b0000);
    assign w_toward_y = (i_target_y < r_y) ? DIR_UP   : ((i_target_y > r_y) ? DIR_DOWN  : 4'b0000);
    assign w_x_major  = (w_dx_abs >= w_dy_abs);
    assign w_pref     = w_x_major ? w_toward_x : w_toward_y;
    assign w_minor    = w_x_major ? w_toward_y : w_toward_x;
    assign w_choice   = ((w_pref & w_cand) != 4'b0000)  ? w_pref  :
                        ((w_minor & w_cand) != 4'b0000) ? w_minor : w_pick;
`else
    assign w_choice = w_pick;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_WAIT;
            r_x        <= 10'(START_X);
            r_y        <= 10'(START_Y);
            r_dir      <= 4'b0000;
            r_next_dir <= 4'b0000;
            r_moving   <= 1'b0;
            r_stuck    <= 1'b0;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    if (i_step_tick) begin
                        r_state  <= ST_DECIDE;
                        r_moving <= 1'b1;
                    end
                end
                ST_DECIDE: begin
                    r_state <= ST_MOVE;
                    if (i_valid == 4'b0000) begin
                        r_stuck <= 1'b1;
                    end else begin
                        r_stuck    <= 1'b0;
                        r_next_dir <= w_choice;
                    end
                end
                ST_MOVE: begin
                    r_state  <= ST_WAIT;
                    r_moving <= 1'b0;
                    if (!r_stuck) begin
                        r_dir <= r_next_dir;
                        case (r_next_dir)
                            DIR_DOWN:  r_y <= r_y + 10'd1;
                            DIR_UP:    r_y <= r_y - 10'd1;
                            DIR_RIGHT: r_x <= r_x + 10'd1;
                            DIR_LEFT:  r_x <= r_x - 10'd1;
                            default:   r_x <= r_x;
                        endcase
                    end
                end
                default: begin
                    r_state  <= ST_WAIT;
                    r_moving <= 1'b0;
                end
            endcase
        end
    end

    assign o_block_x_reg = r_x;
    assign o_block_y_reg = r_y;
    assign o_dir         = r_dir;
    assign o_moving      = r_moving;
    assign o_stuck       = r_stuck;

endmodule

// File: tb/tb_ghost_move.sv
// Bench for ghost_move: directed corridor/dead-end/blocked/tick-spacing/reset cases,
// then random map walks checked against a per-move reference model.
module tb_ghost_move;
    import ghost_pkg::*;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       tick  = 1'b0;
    logic [3:0] valid = 4'b0000;
    logic [9:0] tgt_x = 10'd0;
    logic [9:0] tgt_y = 10'd0;
    logic [9:0] bx;
    logic [9:0] by;
    logic [3:0] dir;
    logic       moving;
    logic       stuck;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_lfsr;
    int         mx;
    int         my;
    logic [3:0] mdir;
    logic       mstuck;

    ghost_move dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_step_tick   (tick),
        .i_valid       (valid),
`ifdef GHOST_CHASE_EN
        .i_target_x    (tgt_x),
        .i_target_y    (tgt_y),
`endif
        .o_block_x_reg (bx),
        .o_block_y_reg (by),
        .o_dir         (dir),
        .o_moving      (moving),
        .o_stuck       (stuck)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & 8'hB8)};
    endfunction

    always @(posedge clk) m_lfsr <= rst ? 8'hA5 : lfsr_next(m_lfsr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_choice(input logic [3:0] v, input logic [3:0] last,
                                              input logic [1:0] s, input int x, input int y,
                                              input int tx, input int ty);
        logic [3:0] back;
        logic [3:0] cand;
        int         dx;
        int         dy;
        int         b;
        logic [3:0] hx;
        logic [3:0] hy;
        logic [3:0] pref;
        logic [3:0] minor;
        back = {last[2], last[3], last[0], last[1]};
        cand = v & ~back;
        if (cand == 4'b0000) cand = v;
        dx = tx - x;
        dy = ty - y;
        hx = (dx < 0) ? DIR_LEFT : ((dx > 0) ? DIR_RIGHT : 4'b0000);
        hy = (dy < 0) ? DIR_UP   : ((dy > 0) ? DIR_DOWN  : 4'b0000);
        if ((dx < 0 ? -dx : dx) >= (dy < 0 ? -dy : dy)) begin
            pref = hx; minor = hy;
        end else begin
            pref = hy; minor = hx;
        end
`ifdef GHOST_CHASE_EN
        if ((pref & cand) != 4'b0000)  return pref;
        if ((minor & cand) != 4'b0000) return minor;
`endif
        for (int i = 0; i < 4; i++) begin
            b = (int'(s) + i) % 4;
            if (cand[b]) return 4'b0001 << b;
        end
        return 4'b0000;
    endfunction

    task automatic do_reset();
        rst  = 1'b1;
        tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mx     = 20;
        my     = 13;
        mdir   = 4'b0000;
        mstuck = 1'b0;
    endtask

    // One tick-to-move transaction with checks at edges k, k+1 and k+2.
    task automatic txn(input logic [3:0] v, input string tag);
        logic [3:0] ch;
        valid = v;
        tick  = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        ch = exp_choice(v, mdir, m_lfsr[1:0], mx, my, int'(tgt_x), int'(tgt_y));
        check({tag, ".moving_k"}, moving, 1);
        @(posedge clk); #1;
        check({tag, ".stuck_k1"}, stuck, (v == 4'b0000));
        check({tag, ".x_k1"}, bx, mx);
        @(posedge clk); #1;
        mstuck = (v == 4'b0000);
        if (!mstuck) begin
            mdir = ch;
            case (ch)
                DIR_DOWN:  my++;
                DIR_UP:    my--;
                DIR_RIGHT: mx++;
                DIR_LEFT:  mx--;
                default:   ;
            endcase
        end
        check({tag, ".x"}, bx, mx);
        check({tag, ".y"}, by, my);
        check({tag, ".dir"}, dir, mdir);
        check({tag, ".moving"}, moving, 0);
    endtask

    initial begin
        logic [3:0] legal;
        logic [31:0] r;

        do_reset();
        check("reset.x", bx, 20);
        check("reset.y", by, 13);
        check("reset.dir", dir, 0);
        check("reset.moving", moving, 0);
        check("reset.stuck", stuck, 0);

        // Corridor: heading left with left/right open never reverses.
        txn(4'b0001, "first_left");
        for (int i = 0; i < 4; i++) begin
            repeat (i) @(posedge clk);
            #1;
            txn(4'b0011, "corridor");
            check("corridor.dir_left", dir, DIR_LEFT);
        end

        txn(4'b0010, "deadend_r");
        check("deadend_r.dir", dir, DIR_RIGHT);
        txn(4'b0001, "deadend_l");
        check("deadend_l.dir", dir, DIR_LEFT);

        txn(4'b0000, "blocked");
        check("blocked.stuck_held", stuck, 1);
        txn(4'b0011, "unblock");
        check("unblock.stuck", stuck, 0);

        // Tick held for 6 cycles: only two moves fit.
        valid = 4'b0011;
        tick  = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mx = mx - 2;
        check("held_tick.x", bx, mx);
        check("held_tick.dir", dir, DIR_LEFT);
        check("held_tick.moving", moving, 0);

        // Reset landing on the MOVE edge discards the move.
        valid = 4'b0011;
        tick  = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_move.x", bx, 20);
        check("rst_move.y", by, 13);
        check("rst_move.dir", dir, 0);
        check("rst_move.moving", moving, 0);
        rst    = 1'b0;
        mx     = 20;
        my     = 13;
        mdir   = 4'b0000;
        mstuck = 1'b0;

`ifdef GHOST_CHASE_EN
        tgt_x = 10'd2;
        tgt_y = 10'd2;
        txn(4'b1111, "chase");
        check("chase.x19", bx, 19);
        check("chase.dir", dir, DIR_LEFT);
`endif

        // Random walk inside the map with occasional extra blockage.
        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            legal = {(my + 1 < MAP_H), (my > 0), (mx + 1 < MAP_W), (mx > 0)};
            r     = $urandom;
            tgt_x = 10'($urandom_range(0, MAP_W - 1));
            tgt_y = 10'($urandom_range(0, MAP_H - 1));
            txn(legal & ((r[1:0] == 2'b00) ? r[7:4] : 4'b1111), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
